// File: rtl/spi_baud_clock_gen.sv
// ---------------------------------------------------------------------------
// spi_baud_clock_gen
//
// Master-mode SCK generator and bit-timing engine for the SPI block. It sits
// between the control-register decode and the shift-register datapath: it
// derives the SCK half-period from SPIBR and drives the SCK pin level. It
// also tells the datapath exactly when to capture MISO (sample_en) and when
// to advance MOSI (shift_en).
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   spe, mstr    SPI enable / master select; dropping either aborts a frame
//   cpol, cpha   clock polarity / phase, captured when a frame starts
//   spiswai,
//   wait_mode    both high freezes a running frame in place
//   baud_reg     SPIBR: [6:4]=SPPR, [2:0]=SPR, captured when a frame starts
//   start        one-cycle frame request, honoured only while idle
//   busy         frame in progress (start accepted until frame_done + 1)
//   sclk         SCK pin level
//   sample_en    one-cycle strobe: capture the MISO bit
//   shift_en     one-cycle strobe: advance the MOSI bit
//   frame_done   one-cycle end-of-frame pulse
//   bit_cnt      number of bits sampled so far in the current frame
// ---------------------------------------------------------------------------
module spi_baud_clock_gen #(
  parameter int FRAME_BITS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          spe,
  input  logic                          mstr,
  input  logic                          cpol,
  input  logic                          cpha,
  input  logic                          spiswai,
  input  logic                          wait_mode,
  input  logic [7:0]                    baud_reg,
  input  logic                          start,
  output logic                          busy,
  output logic                          sclk,
  output logic                          sample_en,
  output logic                          shift_en,
  output logic                          frame_done,
  output logic [$clog2(FRAME_BITS):0]   bit_cnt
);

  localparam int CW        = $clog2(FRAME_BITS) + 1;
  localparam int EW        = $clog2(2 * FRAME_BITS) + 1;
  localparam int LAST_EDGE = 2 * FRAME_BITS;

  // DONE is the single cycle in which frame_done is high; busy is still set
  // there so that a start arriving alongside frame_done is dropped.
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACTIVE,
    HOLD,
    DONE
  } state_t;

  state_t        state;
  logic [10:0]   half_cnt;
  logic [10:0]   half_reload;
  logic [EW-1:0] edge_cnt;
  logic          cpha_q;

  logic [10:0]   half_live;
  logic [10:0]   reload_live;
  logic [EW-1:0] next_edge;
  logic          leading;
  logic          do_sample;
  logic          do_shift;
  logic          abort;
  logic          freeze;
  logic          unused_baud_bits;

  // Half-period H = (SPPR+1) * 2^SPR, 1..1024. The counter runs H-1 down to
  // 0, so storing H-1 keeps the reload within 10 significant bits.
  assign half_live   = 11'(({8'd0, baud_reg[6:4]} + 11'd1) << baud_reg[2:0]);
  assign reload_live = half_live - 11'd1;

  assign unused_baud_bits = baud_reg[7] ^ baud_reg[3];

  // Edges are numbered from 1; odd edges move sclk away from its idle level.
  assign next_edge = edge_cnt + EW'(1);
  assign leading   = next_edge[0];
  assign do_sample = cpha_q ? !leading : leading;
  assign do_shift  = cpha_q ? leading
                            : (!leading && (next_edge <= EW'(LAST_EDGE - 2)));

  // Abort takes priority over freeze. The whole frame, including DONE,
  // stalls while frozen.
  assign abort  = (state != IDLE) && (!spe || !mstr);
  assign freeze = (state != IDLE) && wait_mode && spiswai;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      sclk        <= 1'b0;
      sample_en   <= 1'b0;
      shift_en    <= 1'b0;
      frame_done  <= 1'b0;
      bit_cnt     <= '0;
      half_cnt    <= '0;
      half_reload <= '0;
      edge_cnt    <= '0;
      cpha_q      <= 1'b0;
    end else begin
      sample_en  <= 1'b0;
      shift_en   <= 1'b0;
      frame_done <= 1'b0;

      if (abort) begin
        state    <= IDLE;
        busy     <= 1'b0;
        sclk     <= cpol;
        bit_cnt  <= '0;
        half_cnt <= '0;
        edge_cnt <= '0;
      end else if (freeze) begin
        state <= state;
      end else begin
        case (state)
          IDLE: begin
            sclk <= cpol;
            if (!spe || !mstr) begin
              bit_cnt <= '0;
            end
            if (start && spe && mstr) begin
              state       <= SETUP;
              busy        <= 1'b1;
              half_cnt    <= reload_live;
              half_reload <= reload_live;
              cpha_q      <= cpha;
              bit_cnt     <= '0;
              edge_cnt    <= '0;
            end
          end

          // SETUP only waits for the first half-period; from then on each
          // expiry of the half-period counter is one sclk edge.
          SETUP, ACTIVE: begin
            if (half_cnt == 11'd0) begin
              half_cnt  <= half_reload;
              sclk      <= ~sclk;
              edge_cnt  <= next_edge;
              sample_en <= do_sample;
              shift_en  <= do_shift;
              if (do_sample) begin
                bit_cnt <= bit_cnt + CW'(1);
              end
              if (next_edge == EW'(LAST_EDGE)) begin
                state <= HOLD;
              end else begin
                state <= ACTIVE;
              end
            end else begin
              half_cnt <= half_cnt - 11'd1;
            end
          end

          HOLD: begin
            if (half_cnt == 11'd0) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              half_cnt <= half_cnt - 11'd1;
            end
          end

          DONE: begin
            busy     <= 1'b0;
            edge_cnt <= '0;
            state    <= IDLE;
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_baud_clock_gen.sv
// ---------------------------------------------------------------------------
// tb_spi_baud_clock_gen
//
// Directed bench for spi_baud_clock_gen. Each frame is launched by
// applyStimulus, which observes the outputs once per cycle on the falling
// clock edge. Cycle k is counted from the cycle in which start was high.
// Optional hooks inject mid-frame events: a baud change, an spe drop,
// a wait freeze and extra start pulses. Expected values are hand-computed
// from the timing rules: edge n at k = 1 + n*H, frame_done at
// k = 1 + (2*FRAME_BITS+1)*H.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_spi_baud_clock_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       spe;
  logic       mstr;
  logic       cpol;
  logic       cpha;
  logic       spiswai;
  logic       wait_mode;
  logic [7:0] baud_reg;
  logic       start;
  logic       busy;
  logic       sclk;
  logic       sample_en;
  logic       shift_en;
  logic       frame_done;
  logic [3:0] bit_cnt;

  int checks   = 0;
  int failures = 0;

  // Frame observations
  int   busy_at, first_edge, last_edge, n_edge, n_sample, n_shift;
  int   bad_level, n_done, done_at, done_bitcnt, low_at;
  int   low_sclk, low_bitcnt, low_strobe, frozen_act, chain_busy;

  // Hooks (0 or -1 = disabled)
  int         baud_change_edge;
  logic [7:0] baud_new;
  int         spe_drop_sample;
  int         freeze_k, freeze_len;
  logic       freeze_swai;
  int         restart_k, restart_k2;
  int         chain_start;

  spi_baud_clock_gen #(.FRAME_BITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .spe        (spe),
    .mstr       (mstr),
    .cpol       (cpol),
    .cpha       (cpha),
    .spiswai    (spiswai),
    .wait_mode  (wait_mode),
    .baud_reg   (baud_reg),
    .start      (start),
    .busy       (busy),
    .sclk       (sclk),
    .sample_en  (sample_en),
    .shift_en   (shift_en),
    .frame_done (frame_done),
    .bit_cnt    (bit_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clearHooks();
    baud_change_edge = -1;
    baud_new         = 8'h00;
    spe_drop_sample  = -1;
    freeze_k         = -1;
    freeze_len       = 0;
    freeze_swai      = 1'b0;
    restart_k        = -1;
    restart_k2       = -1;
    chain_start      = 0;
  endtask

  task automatic applyStimulus(input logic [7:0] baud, input logic pol,
                               input logic pha, input int limit);
    logic prev_sclk;
    logic [3:0] prev_bitcnt;
    logic exp_sample_lvl;
    logic baud_done;
    logic spe_done;
    busy_at = 0; first_edge = 0; last_edge = 0; n_edge = 0;
    n_sample = 0; n_shift = 0; bad_level = 0; n_done = 0; done_at = 0;
    done_bitcnt = 0; low_at = 0; low_sclk = 0; low_bitcnt = 0;
    low_strobe = 0; frozen_act = 0; chain_busy = 0;
    baud_done = 1'b0;
    spe_done  = 1'b0;
    exp_sample_lvl = pha ? pol : !pol;

    @(negedge clk);
    baud_reg = baud;
    cpol     = pol;
    cpha     = pha;
    repeat (2) @(negedge clk);
    start       = 1'b1;
    prev_sclk   = sclk;
    prev_bitcnt = bit_cnt;

    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy && busy_at == 0) busy_at = k;
      if (sclk != prev_sclk) begin
        n_edge++;
        if (first_edge == 0) first_edge = k;
        last_edge = k;
      end
      if (sample_en) begin
        n_sample++;
        if (sclk != exp_sample_lvl) bad_level++;
      end
      if (shift_en) begin
        n_shift++;
        if (sclk == exp_sample_lvl) bad_level++;
      end
      if (frame_done) begin
        n_done++;
        done_at     = k;
        done_bitcnt = bit_cnt;
      end
      if (freeze_k > 0 && k > freeze_k && k <= freeze_k + freeze_len) begin
        if (sample_en || shift_en || sclk != prev_sclk || bit_cnt != prev_bitcnt)
          frozen_act++;
      end
      if (busy_at != 0 && !busy) begin
        low_at     = k;
        low_sclk   = sclk;
        low_bitcnt = bit_cnt;
        low_strobe = sample_en | shift_en | frame_done;
        if (chain_start != 0) begin
          start = 1'b1;
          @(negedge clk);
          start      = 1'b0;
          chain_busy = busy;
        end
        break;
      end
      if (busy_at == 0 && k >= 4) break;

      if (!baud_done && baud_change_edge > 0 && n_edge == baud_change_edge) begin
        baud_reg  = baud_new;
        baud_done = 1'b1;
      end
      if (!spe_done && spe_drop_sample > 0 && n_sample == spe_drop_sample) begin
        spe      = 1'b0;
        spe_done = 1'b1;
      end
      if (k == freeze_k) begin
        wait_mode = 1'b1;
        spiswai   = freeze_swai;
      end
      if (freeze_k > 0 && k == freeze_k + freeze_len) begin
        wait_mode = 1'b0;
        spiswai   = 1'b0;
      end
      if (k == restart_k || k == restart_k2) start = 1'b1;
      prev_sclk   = sclk;
      prev_bitcnt = bit_cnt;
    end

    start     = 1'b0;
    wait_mode = 1'b0;
    spiswai   = 1'b0;
    spe       = 1'b1;
  endtask

  initial begin
    int busy_seen;
    int finished;
    rst = 1'b1; spe = 1'b1; mstr = 1'b1; cpol = 1'b1; cpha = 1'b0;
    spiswai = 1'b0; wait_mode = 1'b0; baud_reg = 8'h00; start = 1'b0;
    clearHooks();

    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                {23'd0, busy, sclk, sample_en, shift_en, frame_done, bit_cnt}, 32'd0);
    rst  = 1'b0;
    cpol = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] frame H=1 cpol=0 cpha=0");
    applyStimulus(8'h00, 1'b0, 1'b0, 60);
    checkOutput("h1_busy_at",     busy_at,     1);
    checkOutput("h1_first_edge",  first_edge,  2);
    checkOutput("h1_last_edge",   last_edge,   17);
    checkOutput("h1_edges",       n_edge,      16);
    checkOutput("h1_samples",     n_sample,    8);
    checkOutput("h1_shifts",      n_shift,     7);
    checkOutput("h1_strobe_lvl",  bad_level,   0);
    checkOutput("h1_done_at",     done_at,     18);
    checkOutput("h1_done_count",  n_done,      1);
    checkOutput("h1_done_bitcnt", done_bitcnt, 8);
    checkOutput("h1_busy_low_at", low_at,      19);
    checkOutput("h1_bitcnt_hold", low_bitcnt,  8);

    cpol = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_sclk_cpol1", sclk, 1);
    checkOutput("idle_bitcnt_hold", bit_cnt, 8);

    $display("[TB] frame H=8 cpol=1 cpha=1");
    applyStimulus(8'h12, 1'b1, 1'b1, 200);
    checkOutput("h8_busy_at",    busy_at,    1);
    checkOutput("h8_first_edge", first_edge, 9);
    checkOutput("h8_edges",      n_edge,     16);
    checkOutput("h8_samples",    n_sample,   8);
    checkOutput("h8_shifts",     n_shift,    8);
    checkOutput("h8_strobe_lvl", bad_level,  0);
    checkOutput("h8_done_at",    done_at,    137);
    checkOutput("h8_busy_low",   low_at,     138);
    checkOutput("h8_end_sclk",   low_sclk,   1);

    $display("[TB] mid-frame baud change");
    clearHooks();
    baud_change_edge = 4;
    baud_new         = 8'h77;
    applyStimulus(8'h00, 1'b0, 1'b0, 60);
    checkOutput("bchg_edges",     n_edge,    16);
    checkOutput("bchg_last_edge", last_edge, 17);
    checkOutput("bchg_done_at",   done_at,   18);
    baud_reg = 8'h00;

    $display("[TB] spe abort after third sample");
    clearHooks();
    spe_drop_sample = 3;
    applyStimulus(8'h00, 1'b1, 1'b0, 60);
    checkOutput("abort_low_at",  low_at,     7);
    checkOutput("abort_no_done", n_done,     0);
    checkOutput("abort_sclk",    low_sclk,   1);
    checkOutput("abort_bitcnt",  low_bitcnt, 0);
    checkOutput("abort_strobes", low_strobe, 0);
    checkOutput("abort_samples", n_sample,   3);
    clearHooks();
    applyStimulus(8'h00, 1'b1, 1'b0, 60);
    checkOutput("after_abort_done_at", done_at,  18);
    checkOutput("after_abort_samples", n_sample, 8);
    checkOutput("after_abort_shifts",  n_shift,  7);
    checkOutput("after_abort_lvl",     bad_level, 0);

    $display("[TB] wait freeze for 20 cycles, H=2");
    clearHooks();
    freeze_k = 10; freeze_len = 20; freeze_swai = 1'b1;
    applyStimulus(8'h01, 1'b0, 1'b0, 120);
    checkOutput("frz_done_at",  done_at,    55);
    checkOutput("frz_activity", frozen_act, 0);
    checkOutput("frz_samples",  n_sample,   8);
    checkOutput("frz_edges",    n_edge,     16);
    clearHooks();
    freeze_k = 10; freeze_len = 20; freeze_swai = 1'b0;
    applyStimulus(8'h01, 1'b0, 1'b0, 120);
    checkOutput("nofrz_done_at", done_at, 35);

    $display("[TB] start with mstr low");
    clearHooks();
    mstr = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0, 20);
    checkOutput("mstr0_busy_at", busy_at, 0);
    mstr = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] start while busy and alongside frame_done");
    clearHooks();
    restart_k  = 5;
    restart_k2 = 18;
    applyStimulus(8'h00, 1'b0, 1'b0, 60);
    checkOutput("rstart_edges",   n_edge,  16);
    checkOutput("rstart_done_at", done_at, 18);
    checkOutput("rstart_low_at",  low_at,  19);
    busy_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    checkOutput("rstart_ignored", busy_seen, 0);

    $display("[TB] start in first idle cycle");
    clearHooks();
    chain_start = 1;
    applyStimulus(8'h00, 1'b0, 1'b0, 60);
    checkOutput("chain_busy", chain_busy, 1);
    finished = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin
        finished = 1;
        break;
      end
    end
    checkOutput("chain_finished", finished, 1);

    $display("[TB] async reset mid-frame");
    clearHooks();
    baud_reg = 8'h00; cpol = 1'b1; cpha = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    checkOutput("pre_rst_bitcnt_nz", (bit_cnt != 4'd0), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_outputs",
                {23'd0, busy, sclk, sample_en, shift_en, frame_done, bit_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_baud_clock_gen.md
Name: spi_baud_clock_gen

Overview:
- Master-mode SCK generator and bit-timing engine, directly downstream of the SPI control-register decode.
- Consumes decoded spe/mstr/cpol/cpha/spiswai and the SPIBR baud register.
- Produces the SCK pin level plus single-cycle sample/shift strobes for the shift-register datapath, framed by a start/busy/frame_done handshake.

Parameters:
- FRAME_BITS, 8: bits per transfer. Edge count per frame = 2*FRAME_BITS.

Ports:
- clk  in  1  system bus clock
- rst  in  1  reset
- spe  in  1  SPI enable; low forces IDLE
- mstr  in  1  master select; start ignored when low
- cpol  in  1  clock polarity; SCK idle level
- cpha  in  1  clock phase
- spiswai  in  1  stop-in-wait enable
- wait_mode  in  1  CPU wait-mode indicator
- baud_reg  in  8  SPIBR: [6:4]=SPPR, [2:0]=SPR, bits 7 and 3 ignored
- start  in  1  one-cycle request to begin a frame
- busy  out  1  frame in progress
- sclk  out  1  SCK output level
- sample_en  out  1  one-cycle strobe: capture MISO bit
- shift_en  out  1  one-cycle strobe: advance MOSI bit
- frame_done  out  1  one-cycle end-of-frame pulse
- bit_cnt  out  clog2(FRAME_BITS)+1  bits sampled so far in the current frame

Behaviour:
- Reset is asynchronous and active-high on rst; clock is clk.
- Reset values:
  - sclk=0, busy=0, sample_en=0, shift_en=0, frame_done=0, bit_cnt=0.
  - State=IDLE; all internal counters 0.
- Divisor = (SPPR+1)*2^(SPR+1). Half-period H = (SPPR+1)*2^SPR clk cycles, range 1..1024, 11-bit counter.
- Latching at start: baud_reg, cpol and cpha are captured when start is accepted. Changes mid-frame are ignored.
- IDLE:
  - sclk follows cpol every cycle, registered with 1-cycle lag.
  - start is accepted only when spe=1, mstr=1 and not busy; otherwise it is dropped, with no queueing.
- On accept, the next cycle (B): busy=1, state=SETUP, half-period counter loaded.
- SETUP: after H cycles, the first sclk toggle occurs at B+H; state becomes ACTIVE.
- ACTIVE:
  - sclk toggles every H cycles; edges are numbered 1..2*FRAME_BITS.
  - Odd edges are leading (away from cpol); even edges are trailing.
  - Strobes pulse in the same cycle sclk toggles.
  - cpha=0:
    - sample_en on every leading edge.
    - shift_en on trailing edges 2..2*FRAME_BITS-2.
    - The first bit is presented before the first edge by the datapath.
  - cpha=1:
    - shift_en on every leading edge.
    - sample_en on every trailing edge.
  - bit_cnt increments on each sample_en.
  - After edge 2*FRAME_BITS (sclk back at cpol), state becomes HOLD.
- HOLD:
  - After H cycles, frame_done=1 for one cycle at B+(2*FRAME_BITS+1)*H.
  - busy drops the following cycle; state returns to IDLE; bit_cnt holds FRAME_BITS until the next accepted start clears it.
- Wait freeze: when wait_mode=1 and spiswai=1 in any non-IDLE state, all counters, state and sclk freeze and no strobes are issued. The frame resumes exactly where it stopped when either signal drops.
- spe=0 in any state: immediate abort to IDLE next cycle.
  - busy=0, sclk=cpol, bit_cnt=0.
  - No frame_done; no strobes in the abort cycle.
- mstr falling mid-frame: treated identically to spe=0 (abort).
- start while busy: ignored. A start in the same cycle as frame_done is ignored; a new start is accepted from the cycle busy=0.
- Simultaneous abort and freeze: abort wins.
- Reset mid-frame: all outputs return to reset values asynchronously.

Test Plan:
- baud_reg=0x00 (H=1), cpol=0, cpha=0, start at T:
  - busy=1 at T+1; sclk toggles at T+2..T+17.
  - 8 sample_en pulses on rising edges; 7 shift_en pulses.
  - frame_done at T+18; busy=0 at T+19; bit_cnt=8.
- baud_reg=0x12 (SPPR=1, SPR=2, H=8), cpol=1, cpha=1:
  - sclk idles 1, first falls 8 cycles after busy.
  - shift_en on falling edges, sample_en on rising edges.
  - frame_done 136 cycles after busy rises.
- Mid-frame baud_reg change 0x00→0x77 after edge 4: edge spacing stays 1 cycle; frame length unchanged.
- spe dropped after 3rd sample_en:
  - Next cycle busy=0, sclk=cpol, bit_cnt=0.
  - No frame_done; a subsequent start runs a full frame.
- wait_mode=1 with spiswai=1 for 20 cycles during ACTIVE (H=2):
  - sclk, bit_cnt and strobes are frozen.
  - frame_done is delayed by exactly 20 cycles; with spiswai=0 the same stimulus causes no delay.
- Handshake edge cases:
  - start with mstr=0 → busy stays 0.
  - start during busy or coincident with frame_done → ignored.
  - Async rst asserted mid-ACTIVE → all outputs 0 within the same cycle.
